// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam int XLEN   = 32;
    localparam int STRB_W = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [STRB_W-1:0] wstrb;
    } req_t;

endpackage

// File: rtl/dmem_if.sv
// CPU <-> data-memory request/response channels (valid/ready each way).
interface dmem_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage split into byte lanes; byte-masked write, registered read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [STRB_W-1:0] wstrb_i,
    output logic [XLEN-1:0]   rdata_o
);

    for (genvar l = 0; l < STRB_W; l++) begin : g_lane
        logic [7:0] mem_q [DEPTH];
        logic [7:0] rd_q;

        // Storage is intentionally not reset; contents survive rst_n.
        always_ff @(posedge clk) begin
            if (en_i && we_i && wstrb_i[l]) mem_q[idx_i] <= wdata_i[8*l +: 8];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)            rd_q <= '0;
            else if (en_i && !we_i) rd_q <= mem_q[idx_i];
        end

        assign rdata_o[8*l +: 8] = rd_q;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, WAIT_CYCLES wait states, registered response.
// Define DMEM_ERR_EN to flag misaligned / out-of-range accesses via resp_err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    dmem_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    req_t               req_q, req_d;
    logic               init_q;
    logic               load_q, load_d;
    logic               err_q, err_d;

    req_t               in_req, acc_req;
    logic               acc;
    logic               acc_err;
    logic [IDX_W-1:0]   acc_idx;
    logic [XLEN-1:0]    arr_rdata;

    assign in_req = '{we: bus.req_we, addr: bus.req_addr,
                      wdata: bus.req_wdata, wstrb: bus.req_wstrb};

    // With no wait states the access edge is the accept edge, so use the live request.
    assign acc_req = (WAIT_CYCLES == 0) ? in_req : req_q;
    assign acc_idx = acc_req.addr[2 +: IDX_W];

`ifdef DMEM_ERR_EN
    localparam logic [XLEN-1:0] ADDR_LIM = XLEN'(DEPTH * 4);
    assign acc_err = (acc_req.addr[1:0] != 2'b00) || (acc_req.addr >= ADDR_LIM);
`else
    logic unused_addr;
    assign unused_addr = ^{acc_req.addr[1:0], acc_req.addr[XLEN-1:2+IDX_W]};
    assign acc_err     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        load_d  = load_q;
        err_d   = err_q;
        acc     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && init_q) begin
                    req_d = in_req;
                    cnt_d = CNT_W'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        acc     = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    acc     = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (acc) begin
            load_d = !acc_req.we && !acc_err;
            err_d  = acc_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            init_q  <= 1'b0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            init_q  <= 1'b1;
            load_q  <= load_d;
            err_q   <= err_d;
        end
    end

    dmem_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (acc && !acc_err),
        .we_i    (acc_req.we),
        .idx_i   (acc_idx),
        .wdata_i (acc_req.wdata),
        .wstrb_i (acc_req.wstrb),
        .rdata_o (arr_rdata)
    );

    // Handshake outputs come only from flops; init_q keeps ready low through reset.
    assign bus.req_ready  = (state_q == ST_IDLE) && init_q;
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_rdata = load_q ? arr_rdata : '0;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder with 1 wait state, a second with 3 for the reset-in-WAIT case.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst_n, rst3_n;
    logic sel;
    logic v, we, rr;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_if bus1 ();
    dmem_if bus3 ();

    assign bus1.req_valid = v && !sel;
    assign bus3.req_valid = v && sel;
    assign bus1.resp_ready = rr && !sel;
    assign bus3.resp_ready = rr && sel;
    assign bus1.req_we = we;     assign bus3.req_we = we;
    assign bus1.req_addr = addr; assign bus3.req_addr = addr;
    assign bus1.req_wdata = wdata; assign bus3.req_wdata = wdata;
    assign bus1.req_wstrb = wstrb; assign bus3.req_wstrb = wstrb;

    logic        rdy, rvld, rerr;
    logic [31:0] rdata;
    assign rdy   = sel ? bus3.req_ready  : bus1.req_ready;
    assign rvld  = sel ? bus3.resp_valid : bus1.resp_valid;
    assign rdata = sel ? bus3.resp_rdata : bus1.resp_rdata;
    assign rerr  = sel ? bus3.resp_err   : bus1.resp_err;

    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
    );
    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst3_n), .bus(bus3.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait for its response and complete the handshake.
    // lat counts edges from the accept edge (inclusive) to resp_valid.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output logic e,
                          output int lat);
        int n = 0;
        we = w; addr = a; wdata = d; wstrb = s; v = 1'b1; rr = 1'b0;
        while (!rdy && n < 50) begin tick(); n++; end
        if (!rdy) chk("accept_timeout", 32'd0, 32'd1);
        tick();
        v = 1'b0;
        lat = 1;
        while (!rvld && lat < 50) begin tick(); lat++; end
        rd = rdata;
        e  = rerr;
        rr = 1'b1;
        tick();
        rr = 1'b0;
    endtask

    logic [31:0] rd;
    logic        e;
    int          lat;
    int          n;

    initial begin
        sel = 1'b0; v = 1'b0; we = 1'b0; rr = 1'b0;
        addr = '0; wdata = '0; wstrb = '0;
        rst_n = 1'b0; rst3_n = 1'b0;

        // Reset behaviour
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ready", 32'(rdy), 32'd0);
            chk("rst_valid", 32'(rvld), 32'd0);
        end
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", 32'(rerr), 32'd0);
        rst_n = 1'b1; rst3_n = 1'b1;
        #1;
        chk("ready_before_edge", 32'(rdy), 32'd0);
        tick();
        chk("ready_after_edge", 32'(rdy), 32'd1);

        // Full-word store then load
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat);
        chk("st_lat", 32'(lat), 32'd2);
        chk("st_rdata", rd, 32'd0);
        chk("st_err", 32'(e), 32'd0);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
        chk("ld_lat", 32'(lat), 32'd2);
        chk("ld_rdata", rd, 32'hDEADBEEF);
        chk("ld_err", 32'(e), 32'd0);

        // Byte-lane store
        do_req(1'b1, 32'h10, 32'h000000AA, 4'h1, rd, e, lat);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
        chk("strb_rdata", rd, 32'hDEADBEAA);

        // Backpressure: response held while a second request waits
        we = 1'b0; addr = 32'h10; v = 1'b1; rr = 1'b0;
        n = 0;
        while (!rdy && n < 50) begin tick(); n++; end
        tick();
        we = 1'b1; addr = 32'h14; wdata = 32'h11223344; wstrb = 4'hF;
        n = 0;
        while (!rvld && n < 50) begin tick(); n++; end
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(rvld), 32'd1);
            chk("bp_rdata", rdata, 32'hDEADBEAA);
            chk("bp_ready", 32'(rdy), 32'd0);
            tick();
        end
        rr = 1'b1;
        tick();
        rr = 1'b0;
        chk("bp_ready_idle", 32'(rdy), 32'd1);
        chk("bp_valid_idle", 32'(rvld), 32'd0);
        tick();
        v = 1'b0;
        chk("bp_accepted", 32'(rdy), 32'd0);
        n = 0;
        while (!rvld && n < 50) begin tick(); n++; end
        chk("bp_st_valid", 32'(rvld), 32'd1);
        chk("bp_st_rdata", rdata, 32'd0);
        rr = 1'b1;
        tick();
        rr = 1'b0;
        do_req(1'b0, 32'h14, 32'h0, 4'h0, rd, e, lat);
        chk("bp_ld_rdata", rd, 32'h11223344);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
        chk("bp_ld_old", rd, 32'hDEADBEAA);

        // Out-of-range address
        do_req(1'b0, 32'h1010, 32'h0, 4'h0, rd, e, lat);
        chk("oor_lat", 32'(lat), 32'd2);
`ifdef DMEM_ERR_EN
        chk("oor_rdata", rd, 32'd0);
        chk("oor_err", 32'(e), 32'd1);
        do_req(1'b1, 32'h12, 32'h55555555, 4'hF, rd, e, lat);
        chk("mis_err", 32'(e), 32'd1);
        chk("mis_lat", 32'(lat), 32'd2);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
        chk("mis_unchanged", rd, 32'hDEADBEAA);
        chk("mis_ld_err", 32'(e), 32'd0);
`else
        chk("wrap_rdata", rd, 32'hDEADBEAA);
        chk("wrap_err", 32'(e), 32'd0);
`endif

        // Three wait states, reset during WAIT drops the store
        sel = 1'b1;
        do_req(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, rd, e, lat);
        chk("w3_st_lat", 32'(lat), 32'd4);
        we = 1'b1; addr = 32'h20; wdata = 32'h12345678; wstrb = 4'hF; v = 1'b1;
        n = 0;
        while (!rdy && n < 50) begin tick(); n++; end
        tick();
        v = 1'b0;
        tick();
        chk("w3_wait_valid", 32'(rvld), 32'd0);
        rst3_n = 1'b0;
        #1;
        chk("w3_rst_ready", 32'(rdy), 32'd0);
        tick();
        tick();
        rst3_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("w3_no_resp", 32'(rvld), 32'd0);
        end
        do_req(1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat);
        chk("w3_ld_lat", 32'(lat), 32'd4);
        chk("w3_ld_rdata", rd, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
